btn_stepper: RTL and testbench
==============================

Name: btn_stepper

Overview:
- Producer side of the paddle-control interface: turns raw, bouncy, asynchronous board buttons into the clean ply1_up/ply1_down/ply2_up/ply2_down step requests that the paddle position controller consumes.
- Per button: 2-FF synchronizer, then a counter-based debouncer.
- Per player: a direction FSM emits one-cycle step pulses, with hold-to-auto-repeat.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synced cycles needed to accept a new button level (10 ms @ 25 MHz); must be >= 1.
- HOLD_DELAY, 5000000: cycles from the first pulse of a hold to the first repeat pulse; must be >= 1.
- STEP_PERIOD, 250000: cycles between repeat pulses; must be >= 1.
- BTN_ACTIVE_LOW, 0: 1 = raw buttons read 0 when pressed; inverted after the synchronizer.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- btn1_up  in  1  raw player-1 up button, asynchronous
- btn1_down  in  1  raw player-1 down button, asynchronous
- btn2_up  in  1  raw player-2 up button, asynchronous
- btn2_down  in  1  raw player-2 down button, asynchronous
- ply1_up  out  1  one-cycle step-up request, player 1
- ply1_down  out  1  one-cycle step-down request, player 1
- ply2_up  out  1  one-cycle step-up request, player 2
- ply2_down  out  1  one-cycle step-down request, player 2

Behaviour:
- Reset, sampled on posedge clk while rstn=0:
  - synchronizer flops, debounced levels, debounce counters, FSM timers → 0 (released);
  - FSMs → IDLE;
  - all outputs → 0 on the first clock with rstn=0.
  - Reset mid-hold aborts the hold. After release, a still-pressed button must re-debounce (DEBOUNCE_CYCLES) before any pulse.
- Synchronizer: 2 flops per button, then optional inversion per BTN_ACTIVE_LOW.
- Debouncer, per button:
  - counter increments while synced value != debounced level, clears to 0 on any equal cycle;
  - when counter reaches DEBOUNCE_CYCLES, debounced level flips (registered) and counter clears;
  - counter width = $clog2(DEBOUNCE_CYCLES+1); never wraps.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Direction decode, per player: dir = UP if up=1,down=0; DOWN if up=0,down=1; NONE otherwise (both pressed = NONE).
- Player FSM (registered outputs; timer width sized for max(HOLD_DELAY, STEP_PERIOD)):
  - IDLE: dir != NONE → pulse the matching output next cycle, latch dir, timer=0, go HOLD.
  - HOLD: dir differs from latched dir → IDLE, no pulse. Otherwise timer++; at timer = HOLD_DELAY-1 → pulse, timer=0, go REPEAT.
  - REPEAT: dir differs → IDLE. Otherwise timer++; at timer = STEP_PERIOD-1 → pulse, timer=0.
  - Direction reversal while held: one cycle in IDLE, then a new first pulse in the new direction (gap of exactly 1 cycle).
- Output rules:
  - each output high for exactly 1 cycle per pulse;
  - up and down of one player never high together;
  - players are fully independent and may pulse in the same cycle.
- Latency:
  - raw press stable from sampling edge 0 → ply*_ pulse high at edge DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 FSM);
  - release latency is the same, and no pulse follows once dir=NONE is seen.

Optional Feature:
- Macro: BTN_STEPPER_AUTOREPEAT_EN.
- Defined: HOLD/REPEAT behaviour as above.
- Undefined: exactly one pulse per press. The FSM stays in HOLD with no timer (timer logic removed) until dir changes, then returns to IDLE. HOLD_DELAY and STEP_PERIOD are ignored.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_DELAY=6, STEP_PERIOD=3, macro defined unless noted):
- Reset, then btn1_up held from edge 0 → ply1_up=1 at edge 7 only; repeats at edges 13, 16, 19…; ply1_down, ply2_* stay 0.
- btn2_down bouncing (1-cycle low glitches every 3 cycles, then stable high) → a single first pulse exactly 7 cycles after the last glitch ends; no glitch-induced pulses.
- btn1_up and btn1_down both held stable → no ply1 pulses ever; release btn1_down → ply1_up pulse 7 cycles later.
- Hold btn1_up into REPEAT, switch to btn1_down → after down debounces, ply1_down first pulse with no ply1_up pulse after up's debounced release; next ply1_down repeat 6 cycles later.
- Pull rstn=0 for 1 cycle during REPEAT with button still held → outputs 0 from that edge; next pulse 7 cycles after rstn returns to 1.
- Macro undefined: btn1_up held 50 cycles → exactly one ply1_up pulse at edge 7; release and re-press → one more pulse.

Source files
------------

// File: rtl/btn_stepper.sv
// btn_stepper: turns raw, bouncy, asynchronous board buttons into clean
// one-cycle paddle step requests (ply1_up/ply1_down/ply2_up/ply2_down).
// Each button passes through a 2-flop synchronizer and a counter debouncer.
// Each player has a direction FSM that issues a step pulse on press.
// Optional feature macro: BTN_STEPPER_AUTOREPEAT_EN
//   defined   -> holding a direction auto-repeats (HOLD_DELAY, then every STEP_PERIOD)
//   undefined -> exactly one pulse per press; HOLD_DELAY/STEP_PERIOD ignored
module btn_stepper #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_DELAY      = 5000000,
    parameter int STEP_PERIOD     = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn1_up,
    input  logic btn1_down,
    input  logic btn2_up,
    input  logic btn2_down,
    output logic ply1_up,
    output logic ply1_down,
    output logic ply2_up,
    output logic ply2_down
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BTN_STEPPER_AUTOREPEAT_EN
    localparam int TMR_MAX = (HOLD_DELAY > STEP_PERIOD) ? HOLD_DELAY : STEP_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
`endif

    // Reject configurations where any period would be zero cycles.
    if (DEBOUNCE_CYCLES < 1 || HOLD_DELAY < 1 || STEP_PERIOD < 1) begin : g_bad_cfg
        $error("btn_stepper: DEBOUNCE_CYCLES, HOLD_DELAY and STEP_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // Button index: 0 = p1 up, 1 = p1 down, 2 = p2 up, 3 = p2 down.
    logic [3:0]       raw;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       synced;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    dir_t             dir       [2];
    dir_t             dir_q     [2];
    state_t           state_q   [2];
    logic [1:0]       up_q;
    logic [1:0]       dn_q;
`ifdef BTN_STEPPER_AUTOREPEAT_EN
    logic [TMR_W-1:0] timer_q   [2];
`endif

    assign raw    = {btn2_down, btn2_up, btn1_down, btn1_up};
    assign synced = sync2_q ^ {4{BTN_ACTIVE_LOW}};

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count disagreeing cycles; flip level once the count has reached the limit.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (synced[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounced levels and their counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Per-player direction decode; both buttons pressed means no direction.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dir[p] = DIR_NONE;
            if (deb_q[2*p] && !deb_q[2*p+1]) begin
                dir[p] = DIR_UP;
            end else if (!deb_q[2*p] && deb_q[2*p+1]) begin
                dir[p] = DIR_DOWN;
            end
        end
    end

    // Per-player step FSM with registered one-cycle pulse outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            up_q <= '0;
            dn_q <= '0;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= S_IDLE;
                dir_q[p]   <= DIR_NONE;
`ifdef BTN_STEPPER_AUTOREPEAT_EN
                timer_q[p] <= '0;
`endif
            end
        end else begin
            up_q <= '0;
            dn_q <= '0;
            for (int p = 0; p < 2; p++) begin
                case (state_q[p])
                    S_IDLE: begin
                        if (dir[p] != DIR_NONE) begin
                            up_q[p]    <= (dir[p] == DIR_UP);
                            dn_q[p]    <= (dir[p] == DIR_DOWN);
                            dir_q[p]   <= dir[p];
                            state_q[p] <= S_HOLD;
`ifdef BTN_STEPPER_AUTOREPEAT_EN
                            timer_q[p] <= '0;
`endif
                        end
                    end
                    S_HOLD: begin
                        if (dir[p] != dir_q[p]) begin
                            state_q[p] <= S_IDLE;
`ifdef BTN_STEPPER_AUTOREPEAT_EN
                        end else if (timer_q[p] == TMR_W'(HOLD_DELAY - 1)) begin
                            up_q[p]    <= (dir_q[p] == DIR_UP);
                            dn_q[p]    <= (dir_q[p] == DIR_DOWN);
                            timer_q[p] <= '0;
                            state_q[p] <= S_REPEAT;
                        end else begin
                            timer_q[p] <= timer_q[p] + 1'b1;
`endif
                        end
                    end
`ifdef BTN_STEPPER_AUTOREPEAT_EN
                    S_REPEAT: begin
                        if (dir[p] != dir_q[p]) begin
                            state_q[p] <= S_IDLE;
                        end else if (timer_q[p] == TMR_W'(STEP_PERIOD - 1)) begin
                            up_q[p]    <= (dir_q[p] == DIR_UP);
                            dn_q[p]    <= (dir_q[p] == DIR_DOWN);
                            timer_q[p] <= '0;
                        end else begin
                            timer_q[p] <= timer_q[p] + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_q[p] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ply1_up   = up_q[0];
    assign ply1_down = dn_q[0];
    assign ply2_up   = up_q[1];
    assign ply2_down = dn_q[1];

endmodule

// File: tb/tb_btn_stepper.sv
// tb_btn_stepper: directed bench for btn_stepper with a cycle-level reference
// model (pulse times derived arithmetically from press start) and a per-cycle
// compare, plus literal pulse-edge expectations for each scenario.
module tb_btn_stepper;

    localparam int D  = 4;
    localparam int HD = 6;
    localparam int SP = 3;
`ifdef BTN_STEPPER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic btn1_up = 1'b0, btn1_down = 1'b0, btn2_up = 1'b0, btn2_down = 1'b0;
    logic ply1_up, ply1_down, ply2_up, ply2_down;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    btn_stepper #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_DELAY     (HD),
        .STEP_PERIOD    (SP),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn1_up  (btn1_up),
        .btn1_down(btn1_down),
        .btn2_up  (btn2_up),
        .btn2_down(btn2_down),
        .ply1_up  (ply1_up),
        .ply1_down(ply1_down),
        .ply2_up  (ply2_up),
        .ply2_down(ply2_down)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference model state.
    bit m_s1 [4];
    bit m_s2 [4];
    bit m_deb [4];
    int m_run [4];
    int m_act [2];     // 0 = no active press, 1 = up, 2 = down
    int m_start [2];   // edge of the first pulse of the current press
    int m_d [2];
    int m_k;
    bit exp_up [2];
    bit exp_dn [2];
    bit raw [4];

    // Pulse edge logs (DUT and model).
    int q_p1u[$], q_p1d[$], q_p2u[$], q_p2d[$];
    int qm_p1u[$];

    // Model: one evaluation per rising edge; cyc is the number of the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        raw[0] = btn1_up; raw[1] = btn1_down; raw[2] = btn2_up; raw[3] = btn2_down;
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                m_act[p] = 0; m_start[p] = 0; exp_up[p] = 0; exp_dn[p] = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                m_d[p] = (m_deb[2*p] && !m_deb[2*p+1]) ? 1 :
                         (!m_deb[2*p] && m_deb[2*p+1]) ? 2 : 0;
                exp_up[p] = 0;
                exp_dn[p] = 0;
                if (m_act[p] == 0) begin
                    if (m_d[p] != 0) begin
                        m_act[p]   = m_d[p];
                        m_start[p] = cyc;
                        exp_up[p]  = (m_d[p] == 1);
                        exp_dn[p]  = (m_d[p] == 2);
                    end
                end else if (m_d[p] != m_act[p]) begin
                    m_act[p] = 0;
                end else if (AR) begin
                    m_k = cyc - m_start[p];
                    if (m_k == HD || (m_k > HD && (m_k - HD) % SP == 0)) begin
                        exp_up[p] = (m_act[p] == 1);
                        exp_dn[p] = (m_act[p] == 2);
                    end
                end
            end
            // A new level is accepted after D+1 consecutive disagreeing synced samples.
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D + 1) begin
                        m_deb[i] = ~m_deb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    end

    // Scoreboard compare and pulse logging, away from the active edge.
    always @(negedge clk) begin
        if (ply1_up === 1'b1)   q_p1u.push_back(cyc);
        if (ply1_down === 1'b1) q_p1d.push_back(cyc);
        if (ply2_up === 1'b1)   q_p2u.push_back(cyc);
        if (ply2_down === 1'b1) q_p2d.push_back(cyc);
        if (exp_up[0]) qm_p1u.push_back(cyc);
        if (chk_en) begin
            checks++;
            if (ply1_up !== exp_up[0] || ply1_down !== exp_dn[0] ||
                ply2_up !== exp_up[1] || ply2_down !== exp_dn[1]) begin
                errors++;
                $display("FAIL cycle_compare edge %0d: got p1u=%b p1d=%b p2u=%b p2d=%b want p1u=%b p1d=%b p2u=%b p2d=%b",
                         cyc, ply1_up, ply1_down, ply2_up, ply2_down,
                         exp_up[0], exp_dn[0], exp_up[1], exp_dn[1]);
            end
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int count_ge(input int q[$], input int e);
        int n = 0;
        foreach (q[i]) if (q[i] >= e) n++;
        return n;
    endfunction

    function automatic int first_ge(input int q[$], input int e);
        foreach (q[i]) if (q[i] >= e) return q[i];
        return -1;
    endfunction

    function automatic int qget(input int q[$], input int idx);
        if (idx < 0 || idx >= q.size()) return -1;
        return q[idx];
    endfunction

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        q_p1u.delete(); q_p1d.delete(); q_p2u.delete(); q_p2d.delete(); qm_p1u.delete();
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    int e0, e1, e2, g, r;

    // Directed stimulus.
    initial begin
        tick(3);
        chk_en = 1'b1;
        check_int("reset_p1u", int'(ply1_up), 0);
        check_int("reset_p2d", int'(ply2_down), 0);

        // Scenario 1: btn1_up held from edge e0.
        rstn = 1'b1; btn1_up = 1'b1; e0 = cyc + 1;
        wait_until(e0 + 20);
        check_int("s1_model_first", qget(qm_p1u, 0), e0 + 7);
        check_int("s1_first", qget(q_p1u, 0), e0 + 7);
        check_int("s1_count", q_p1u.size(), AR ? 4 : 1);
        check_int("s1_last", qget(q_p1u, q_p1u.size() - 1), AR ? e0 + 19 : e0 + 7);
        check_int("s1_others", q_p1d.size() + q_p2u.size() + q_p2d.size(), 0);
        btn1_up = 1'b0; tick(12); clear_logs();

        // Scenario 2: btn2_down bouncing, then stable.
        for (int n = 0; n < 4; n++) begin
            btn2_down = 1'b1; tick(2);
            btn2_down = 1'b0; tick(1);
        end
        btn2_down = 1'b1; g = cyc + 1;
        wait_until(g + 10);
        check_int("s2_count", q_p2d.size(), 1);
        check_int("s2_first", qget(q_p2d, 0), g + 7);
        check_int("s2_others", q_p1u.size() + q_p1d.size() + q_p2u.size(), 0);
        btn2_down = 1'b0; tick(12); clear_logs();

        // Scenario 3: both p1 buttons held, then release down.
        btn1_up = 1'b1; btn1_down = 1'b1;
        tick(20);
        check_int("s3_both_none", q_p1u.size() + q_p1d.size(), 0);
        btn1_down = 1'b0; e0 = cyc + 1;
        wait_until(e0 + 9);
        check_int("s3_up_count", q_p1u.size(), 1);
        check_int("s3_up_first", qget(q_p1u, 0), e0 + 7);

        // Scenario 4: continue into REPEAT, then reverse to down.
        wait_until(e0 + 17);
        btn1_up = 1'b0; btn1_down = 1'b1; e1 = cyc + 1;
        wait_until(e1 + 16);
        check_int("s4_no_up_after_release", count_ge(q_p1u, e1 + 7), 0);
        check_int("s4_down_first", qget(q_p1d, 0), e1 + 8);
        check_int("s4_down_count", q_p1d.size(), AR ? 2 : 1);
        check_int("s4_down_last", qget(q_p1d, q_p1d.size() - 1), AR ? e1 + 14 : e1 + 8);
        btn1_down = 1'b0; tick(12); clear_logs();

        // Scenario 5: one-cycle reset during REPEAT with the button held.
        btn1_up = 1'b1; e0 = cyc + 1;
        wait_until(e0 + 18);
        rstn = 1'b0; r = cyc + 1;
        tick(1);
        check_int("s5_out_in_reset", int'(ply1_up), 0);
        rstn = 1'b1;
        wait_until(r + 10);
        check_int("s5_after_reset_first", first_ge(q_p1u, r), r + 8);
        check_int("s5_after_reset_count", count_ge(q_p1u, r), 1);
        btn1_up = 1'b0; tick(12); clear_logs();

        // Scenario 6: long hold, then release and re-press.
        btn1_up = 1'b1; e0 = cyc + 1;
        wait_until(e0 + 50);
        check_int("s6_hold_count", q_p1u.size(), AR ? 14 : 1);
        check_int("s6_hold_first", qget(q_p1u, 0), e0 + 7);
        btn1_up = 1'b0; tick(10);
        btn1_up = 1'b1; e2 = cyc + 1;
        wait_until(e2 + 10);
        check_int("s6_repress_count", count_ge(q_p1u, e2), 1);
        check_int("s6_repress_first", first_ge(q_p1u, e2), e2 + 7);
        btn1_up = 1'b0; tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
